// File: rtl/uart_rx_if.sv
// uart_rx_if: output bundle of the UART receiver towards its downstream consumer.
//   o_data       received byte, held until the next good frame
//   o_valid      one-cycle pulse, o_data is new
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_parity_err one-cycle pulse alongside o_valid on parity mismatch (0 without parity)
// Modports: master = receiver side (drives), slave = consumer side (observes).
interface uart_rx_if #(
  parameter int unsigned NB_DATA = 8
) ();
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               o_frame_err;
  logic               o_parity_err;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_parity_err
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_frame_err,
    input o_parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, 8N1 (or 8E1), LSB first, idle-high line.
// Optional even parity is enabled by defining the macro UART_RX_PARITY_EN.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous active-high reset
//   i_tick     oversampling tick, N_TICKS pulses per bit period
//   i_rx_data  serial line, asynchronous to i_clk
//   rx_if      uart_rx_if.master: o_data / o_valid / o_frame_err / o_parity_err
module uart_rx #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned N_TICKS = 16
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rx_data,
  uart_rx_if.master rx_if
);

  localparam int unsigned TickW = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int unsigned BitW  = $clog2(NB_DATA + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(N_TICKS / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(N_TICKS - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(NB_DATA - 1);

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StStart  = 6'b000010,
    StData   = 6'b000100,
    StParity = 6'b001000,
    StStop   = 6'b010000,
    StBreak  = 6'b100000
  } state_e;

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               rx_meta_q, rx_sync_q;
`ifdef UART_RX_PARITY_EN
  logic               par_bit_q, par_bit_d;
  logic               perr_q, perr_d;
`endif

  // Sample point reached on this cycle for the current bit period.
  logic mid_hit, end_hit;
  assign mid_hit = i_tick && (tick_cnt_q == TickMid);
  assign end_hit = i_tick && (tick_cnt_q == TickLast);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Sync FFs reset to the idle level so reset never looks like a start bit.
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= i_rx_data;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end

      StStart: begin
        if (mid_hit) begin
          // A line that is high again by mid start bit was a glitch.
          if (!rx_sync_q) begin
            state_d    = StData;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d    = StIdle;
          end
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (end_hit) begin
          shift_d    = {rx_sync_q, shift_q[NB_DATA-1:1]};
          tick_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (end_hit) begin
          par_bit_d  = rx_sync_q;
          tick_cnt_d = '0;
          state_d    = StStop;
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end

      StStop: begin
        if (end_hit) begin
          tick_cnt_d = '0;
          if (rx_sync_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_bit_q;
`endif
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end

      StBreak: begin
        // Wait out a held-low line so it cannot re-trigger frames.
        if (rx_sync_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = perr_q;
`else
  assign rx_if.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx with hand-written corner sequences.
module tb_uart_rx;

  localparam int unsigned NbData  = 8;
  localparam int unsigned NTicks  = 16;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned BitClks = NTicks * TickDiv;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned ParOn = 1;
`else
  localparam int unsigned ParOn = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick;
  logic rx = 1'b1;

  uart_rx_if #(.NB_DATA(NbData)) rx_if ();

  uart_rx #(
    .NB_DATA(NbData),
    .N_TICKS(NTicks)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_tick   (tick),
    .i_rx_data(rx),
    .rx_if    (rx_if)
  );

  always #5 clk = ~clk;

  // Free-running tick, one pulse every TickDiv clocks.
  int unsigned div_cnt = 0;
  always @(posedge clk) div_cnt <= (div_cnt == TickDiv - 1) ? 0 : div_cnt + 1;
  assign tick = (div_cnt == TickDiv - 1);

  // Output monitor, sampled on the falling edge.
  int unsigned n_valid, n_ferr, n_perr, n_perr_stray;
  longint      cyc = 0;
  longint      valid_cyc_q[$];
  logic [7:0]  got_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_if.o_valid) begin
      n_valid = n_valid + 1;
      got_q.push_back(rx_if.o_data);
      valid_cyc_q.push_back(cyc);
      if (rx_if.o_parity_err) n_perr = n_perr + 1;
    end else if (rx_if.o_parity_err) begin
      n_perr_stray = n_perr_stray + 1;
    end
    if (rx_if.o_frame_err) n_ferr = n_ferr + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_ferr  = 0;
    n_perr  = 0;
    got_q.delete();
    valid_cyc_q.delete();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BitClks) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BitClks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;  // flip has no meaning in 8N1
`endif
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_flip;
    int         exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 0, 8'hFF, 1, 0};  // bad stop bit keeps old data
    vecs[4] = '{8'h81, 1'b1, 1'b0, 1, 8'h81, 0, 0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 1, 8'h5A, 0, int'(ParOn)};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 1, 8'h07, 0, 0};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 1, 8'h07, 0, int'(ParOn)};

    n_perr_stray = 0;
    clear_counts();

    // Reset state.
    repeat (4) @(negedge clk);
    check("reset_data", 64'(rx_if.o_data), 64'h00);
    check("reset_valid", 64'(rx_if.o_valid), 64'h0);
    check("reset_ferr", 64'(rx_if.o_frame_err), 64'h0);
    check("reset_perr", 64'(rx_if.o_parity_err), 64'h0);
    reset = 1'b0;
    idle_bits(2);

    for (int v = 0; v < NV; v++) begin
      clear_counts();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].par_flip);
      idle_bits(3);
      check($sformatf("vec%0d_valid", v), 64'(n_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), 64'(rx_if.o_data), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_ferr", v), 64'(n_ferr), 64'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_perr", v), 64'(n_perr), 64'(vecs[v].exp_perr));
    end

    // Start-bit glitch: low for 4 ticks only.
    clear_counts();
    rx = 1'b0;
    repeat (4 * TickDiv) @(negedge clk);
    idle_bits(3);
    check("glitch_valid", 64'(n_valid), 64'd0);
    check("glitch_ferr", 64'(n_ferr), 64'd0);
    check("glitch_data", 64'(rx_if.o_data), 64'h07);

    // Framing error followed by a long low hold, then a good frame.
    clear_counts();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * TickDiv) @(negedge clk);
    idle_bits(3);
    check("brk_ferr", 64'(n_ferr), 64'd1);
    check("brk_valid", 64'(n_valid), 64'd0);
    check("brk_data", 64'(rx_if.o_data), 64'h07);
    clear_counts();
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(3);
    check("brk_after_valid", 64'(n_valid), 64'd1);
    check("brk_after_data", 64'(rx_if.o_data), 64'h81);

    // Back-to-back frames with no idle gap.
    clear_counts();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(3);
    check("b2b_valid", 64'(n_valid), 64'd2);
    if (n_valid == 2) begin
      check("b2b_first", 64'(got_q[0]), 64'h00);
      check("b2b_second", 64'(got_q[1]), 64'hFF);
      check("b2b_spacing", 64'(valid_cyc_q[1] - valid_cyc_q[0]),
            64'((10 + ParOn) * BitClks));
    end
    check("b2b_ferr", 64'(n_ferr), 64'd0);

    // Reset in the middle of data bit 3 of 0x55.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b0;
    repeat (BitClks / 2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_data", 64'(rx_if.o_data), 64'h00);
    reset = 1'b0;
    idle_bits(4);
    check("midrst_valid", 64'(n_valid), 64'd0);
    check("midrst_ferr", 64'(n_ferr), 64'd0);
    clear_counts();
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(3);
    check("midrst_next_valid", 64'(n_valid), 64'd1);
    check("midrst_next_data", 64'(rx_if.o_data), 64'h3C);

    check("perr_without_valid", 64'(n_perr_stray), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
